// File: rtl/dc_pkg.sv
// dc_pkg: shared types and constants for the data-channel pointer bank.
//   dc_op_t   - 3-bit decoded DC command opcode
//   DIR_FWD/DIR_BWD - direction bit encodings
//   JUMP_CHAN - channel used by JUMP regardless of cmd_chan
package dc_pkg;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_SETF  = 3'd3,
    OP_SETB  = 3'd4,
    OP_JUMP  = 3'd5
  } dc_op_t;

  localparam logic DIR_FWD   = 1'b0;
  localparam logic DIR_BWD   = 1'b1;
  localparam int   JUMP_CHAN = 0;
endpackage

// File: rtl/dc_pointer_bank_if.sv
// dc_pointer_bank_if: command handshake + memory request bus of the pointer bank.
//   cmd_*  : decoded DC command, valid/ready
//   mem_*  : registered memory request, valid/ready
//   master : command source / memory sink (decoder + memory port side)
//   slave  : the pointer bank
interface dc_pointer_bank_if #(
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [2:0]                  cmd_op;
  logic [$clog2(CHANNELS)-1:0] cmd_chan;
  logic [ADDR_WIDTH-1:0]       cmd_value;
  logic                        mem_valid;
  logic                        mem_ready;
  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_chan, cmd_value, mem_ready,
    input  cmd_ready, mem_valid, mem_we, mem_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_chan, cmd_value, mem_ready,
    output cmd_ready, mem_valid, mem_we, mem_addr
  );
endinterface

// File: rtl/dc_pointer_channel.sv
// dc_pointer_channel: one channel's rd/wr pointers and direction bit.
//   adv_rd/adv_wr : post-step the pointer by +/-STRIDE (per dir), modulo 2^ADDR_WIDTH
//   set           : load both pointers with set_value and dir with set_dir (wins over adv)
//   rd_ptr/wr_ptr/dir : registered state
module dc_pointer_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int STRIDE     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  adv_rd,
  input  logic                  adv_wr,
  input  logic                  set,
  input  logic                  set_dir,
  input  logic [ADDR_WIDTH-1:0] set_value,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  dir
);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      dir    <= dc_pkg::DIR_FWD;
    end else if (set) begin
      rd_ptr <= set_value;
      wr_ptr <= set_value;
      dir    <= set_dir;
    end else begin
      // wrap is silent in both directions
      if (adv_rd) rd_ptr <= dir ? rd_ptr - STEP : rd_ptr + STEP;
      if (adv_wr) wr_ptr <= dir ? wr_ptr - STEP : wr_ptr + STEP;
    end
  end
endmodule

// File: rtl/dc_pointer_bank.sv
// dc_pointer_bank: CHANNELS independent pointer channels driven by decoded DC
// commands; issues one registered memory request per READ/WRITE/JUMP and
// post-steps the used pointer by +/-STRIDE.
//   clk, reset_n       : clock, async active-low reset
//   bus (slave)        : cmd_* handshake in, mem_* request out
//   obs_chan           : observation select
//   obs_rd_ptr/wr_ptr/dir : combinational view of the selected channel's state
module dc_pointer_bank
  import dc_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int STRIDE     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  dc_pointer_bank_if.slave            bus,
  input  logic [$clog2(CHANNELS)-1:0] obs_chan,
  output logic [ADDR_WIDTH-1:0]       obs_rd_ptr,
  output logic [ADDR_WIDTH-1:0]       obs_wr_ptr,
  output logic                        obs_dir
);
  localparam int CW = $clog2(CHANNELS);

  logic [CHANNELS-1:0][ADDR_WIDTH-1:0] rd_ptrs, wr_ptrs;
  logic [CHANNELS-1:0]                 dirs;
  logic [CHANNELS-1:0]                 hit;

  logic                  req_valid, req_we;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic          accept, is_rd, is_wr, is_set, set_dir;
  logic [CW-1:0] ch;

  // A stalled request blocks new commands, which also freezes the pointers.
  assign bus.cmd_ready = !req_valid || bus.mem_ready;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    is_rd   = 1'b0;
    is_wr   = 1'b0;
    is_set  = 1'b0;
    set_dir = DIR_FWD;
    ch      = bus.cmd_chan;
    case (bus.cmd_op)
      OP_READ:  is_rd = 1'b1;
      OP_JUMP:  begin is_rd = 1'b1; ch = CW'(JUMP_CHAN); end
      OP_WRITE: is_wr = 1'b1;
      OP_SETF:  begin is_set = 1'b1; set_dir = DIR_FWD; end
      OP_SETB:  begin is_set = 1'b1; set_dir = DIR_BWD; end
      default:  ; // NOP and undefined encodings
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign hit[g] = accept && (ch == CW'(g));

    dc_pointer_channel #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .STRIDE    (STRIDE)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .adv_rd   (hit[g] && is_rd),
      .adv_wr   (hit[g] && is_wr),
      .set      (hit[g] && is_set),
      .set_dir  (set_dir),
      .set_value(bus.cmd_value),
      .rd_ptr   (rd_ptrs[g]),
      .wr_ptr   (wr_ptrs[g]),
      .dir      (dirs[g])
    );
  end

  // Request register: the address is the pre-step pointer value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
    end else if (accept) begin
      req_valid <= is_rd || is_wr;
      if (is_rd || is_wr) begin
        req_we   <= is_wr;
        req_addr <= is_wr ? wr_ptrs[ch] : rd_ptrs[ch];
      end
    end else if (bus.mem_ready) begin
      req_valid <= 1'b0;
    end
  end

  assign bus.mem_valid = req_valid;
  assign bus.mem_we    = req_we;
  assign bus.mem_addr  = req_addr;

  assign obs_rd_ptr = rd_ptrs[obs_chan];
  assign obs_wr_ptr = wr_ptrs[obs_chan];
  assign obs_dir    = dirs[obs_chan];
endmodule

// File: tb/tb_dc_pointer_bank.sv
// tb_dc_pointer_bank: directed self-checking bench for dc_pointer_bank.
module tb_dc_pointer_bank;
  import dc_pkg::*;

  localparam int CH = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    obs_chan;
  logic [AW-1:0] obs_rd_ptr, obs_wr_ptr;
  logic          obs_dir;

  int compared = 0;
  int mismatched = 0;

  dc_pointer_bank_if #(.CHANNELS(CH), .ADDR_WIDTH(AW)) bus ();

  dc_pointer_bank #(.CHANNELS(CH), .ADDR_WIDTH(AW), .STRIDE(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .obs_chan  (obs_chan),
    .obs_rd_ptr(obs_rd_ptr),
    .obs_wr_ptr(obs_wr_ptr),
    .obs_dir   (obs_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] observed, input logic [AW-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] ch, input logic [AW-1:0] val);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_chan  = ch;
    bus.cmd_value = val;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
  endtask

  task automatic obs(input logic [1:0] ch);
    obs_chan = ch;
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_chan  = '0;
    bus.cmd_value = '0;
    bus.mem_ready = 1'b1;
    obs_chan      = '0;
    repeat (2) cyc();

    // reset state
    chk("rst_mem_valid", AW'(bus.mem_valid), 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_cmd_ready", AW'(bus.cmd_ready), 1);
    reset_n = 1'b1;
    cyc();

    // 1: SETF ch1 0x100, then 3 READs
    drive(OP_SETF, 2'd1, 32'h100); cyc();
    chk("t1_setf_no_req", AW'(bus.mem_valid), 0);
    drive(OP_READ, 2'd1, 0); cyc();
    chk("t1_rd0_valid", AW'(bus.mem_valid), 1);
    chk("t1_rd0_we",    AW'(bus.mem_we), 0);
    chk("t1_rd0_addr",  bus.mem_addr, 32'h100);
    cyc();
    chk("t1_rd1_addr",  bus.mem_addr, 32'h104);
    cyc();
    chk("t1_rd2_addr",  bus.mem_addr, 32'h108);
    idle(); cyc();
    chk("t1_drain", AW'(bus.mem_valid), 0);
    obs(2'd1);
    chk("t1_rd_ptr", obs_rd_ptr, 32'h10C);
    chk("t1_wr_ptr", obs_wr_ptr, 32'h100);
    chk("t1_dir",    AW'(obs_dir), 0);

    // 2: SETB ch2 0x8, then 3 WRITEs stepping down through zero
    drive(OP_SETB, 2'd2, 32'h8); cyc();
    drive(OP_WRITE, 2'd2, 0); cyc();
    chk("t2_wr0_we",   AW'(bus.mem_we), 1);
    chk("t2_wr0_addr", bus.mem_addr, 32'h8);
    cyc();
    chk("t2_wr1_addr", bus.mem_addr, 32'h4);
    cyc();
    chk("t2_wr2_addr", bus.mem_addr, 32'h0);
    chk("t2_wr2_we",   AW'(bus.mem_we), 1);
    idle(); cyc();
    obs(2'd2);
    chk("t2_wr_ptr_wrap", obs_wr_ptr, 32'hFFFF_FFFC);
    chk("t2_rd_ptr",      obs_rd_ptr, 32'h8);
    chk("t2_dir",         AW'(obs_dir), 1);

    // 3: stall 4 cycles with a READ waiting
    drive(OP_READ, 2'd1, 0); cyc();
    chk("t3_first_addr", bus.mem_addr, 32'h10C);
    bus.mem_ready = 1'b0;
    obs(2'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall_ready", AW'(bus.cmd_ready), 0);
      chk("t3_stall_valid", AW'(bus.mem_valid), 1);
      chk("t3_stall_addr",  bus.mem_addr, 32'h10C);
      chk("t3_stall_ptr",   obs_rd_ptr, 32'h110);
      cyc();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("t3_resume_ready", AW'(bus.cmd_ready), 1);
    cyc();
    chk("t3_resume_addr0", bus.mem_addr, 32'h110);
    cyc();
    chk("t3_resume_addr1", bus.mem_addr, 32'h114);
    idle(); cyc();
    chk("t3_final_ptr", obs_rd_ptr, 32'h118);

    // 4: JUMP uses channel 0 regardless of cmd_chan
    drive(OP_SETF, 2'd0, 32'h40); cyc();
    drive(OP_JUMP, 2'd3, 0); cyc();
    chk("t4_jump_valid", AW'(bus.mem_valid), 1);
    chk("t4_jump_we",    AW'(bus.mem_we), 0);
    chk("t4_jump_addr",  bus.mem_addr, 32'h40);
    idle(); cyc();
    obs(2'd0);
    chk("t4_ch0_rd_ptr", obs_rd_ptr, 32'h44);
    obs(2'd3);
    chk("t4_ch3_rd_ptr", obs_rd_ptr, 32'h0);
    chk("t4_ch3_wr_ptr", obs_wr_ptr, 32'h0);

    // 5: READ, then SETF ch0 (request retires), then READ ch0 sees new value
    drive(OP_READ, 2'd1, 0); cyc();
    chk("t5_rd_addr", bus.mem_addr, 32'h118);
    drive(OP_SETF, 2'd0, 32'h20); cyc();
    chk("t5_setf_clears_valid", AW'(bus.mem_valid), 0);
    drive(OP_READ, 2'd0, 0); cyc();
    chk("t5_fresh_addr", bus.mem_addr, 32'h20);
    // undefined opcode behaves as NOP
    drive(3'd7, 2'd0, 32'hDEAD); cyc();
    chk("t5_undef_no_req", AW'(bus.mem_valid), 0);
    obs(2'd0);
    chk("t5_undef_ptr", obs_rd_ptr, 32'h24);
    chk("t5_undef_wr",  obs_wr_ptr, 32'h20);
    idle(); cyc();

    // 6: reset while a request is stalled
    bus.mem_ready = 1'b0;
    drive(OP_READ, 2'd2, 0); cyc();
    idle();
    chk("t6_pending_valid", AW'(bus.mem_valid), 1);
    chk("t6_pending_addr",  bus.mem_addr, 32'h8);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", AW'(bus.mem_valid), 0);
    obs(2'd2);
    chk("t6_rst_rd_ptr", obs_rd_ptr, 0);
    chk("t6_rst_wr_ptr", obs_wr_ptr, 0);
    chk("t6_rst_dir",    AW'(obs_dir), 0);
    obs(2'd1);
    chk("t6_rst_ch1_rd", obs_rd_ptr, 0);
    cyc();
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
